gpu_instruction_scheduler: RTL
==============================

GPU_INSTRUCTION_SCHEDULER -- requirements
Module: gpu_instruction_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction FIFO entry count (power of two, 2..16).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 opcode_i  in  4  SHALL carry the instruction opcode from gpu_instruction_decoder.
REQ-005 x1_i/x2_i, rad_i  in  WIDTH_BITS; y1_i/y2_i  in  HEIGHT_BITS; r_i/g_i/b_i  in  CHANNEL_BITS  SHALL carry the instruction operands.
REQ-006 push_i  in  1  SHALL request a one-cycle enqueue of the current operands.
REQ-007 full_o  out  1  SHALL indicate no free FIFO entry; empty_o  out  1  SHALL indicate zero entries.
REQ-008 overflow_o  out  1  SHALL pulse one cycle when a push is dropped.
REQ-009 bad_op_o  out  1  SHALL pulse one cycle when an unsupported opcode is discarded.
REQ-010 line_start_o, circle_start_o  out  1  SHALL be one-cycle start pulses to the line and circle raster engines.
REQ-011 line_done_i, circle_done_i  in  1  SHALL be one-cycle completion pulses from the engines.
REQ-012 x1_o..b_o  out  same widths as inputs  SHALL present the dispatched instruction operands.
REQ-013 busy_o  out  1  SHALL be high when the FSM is not in IDLE.

Function
REQ-014 A push with full_o low SHALL write all operands into the FIFO tail; occupancy is visible the next cycle.
REQ-015 A push with full_o high SHALL be dropped and SHALL assert overflow_o the next cycle; a pop in the same cycle SHALL NOT make room for that push.
REQ-016 FSM states SHALL be IDLE, DISPATCH, WAIT_LINE and WAIT_CIRCLE.
REQ-017 IDLE with FIFO non-empty SHALL pop the head into the output register and go to DISPATCH.
REQ-018 DISPATCH SHALL assert exactly one start pulse selected by the opcode: OP_LINE to line_start_o then WAIT_LINE; OP_CIRCLE to circle_start_o then WAIT_CIRCLE.
REQ-019 Any other opcode in DISPATCH SHALL assert no start, SHALL pulse bad_op_o, and SHALL return to IDLE.
REQ-020 WAIT_x SHALL stay until the matching done_i pulse; a done pulse from the other engine, or any done pulse outside WAIT_x, SHALL be ignored.
REQ-021 On the matching done, the FSM SHALL return to IDLE; a non-empty FIFO re-enters DISPATCH on the following cycle.
REQ-022 x1_o..b_o SHALL remain stable from DISPATCH through the done cycle inclusive.
REQ-023 Latency: push into an empty FIFO while IDLE at cycle N SHALL produce the start pulse at cycle N+2.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be $clog2(DEPTH)+1 bits wide.
REQ-025 A simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged.

Reset
REQ-026 When rst is high at a clock edge, the FSM SHALL go to IDLE and the FIFO SHALL empty.
REQ-027 During and after reset, outputs SHALL be: full_o=0, empty_o=1, busy_o=0, all pulses 0, x1_o..b_o=0.
REQ-028 Reset mid-operation SHALL abandon the in-flight instruction with no further start pulse; a done arriving afterwards SHALL be ignored.

Structure
REQ-029 Package gpu_sched_pkg SHALL hold OP_LINE=4'b0100, OP_CIRCLE=4'b0101, the state enum and a packed instruction struct (opcode plus operands), using the widths from gpu_definitions.vh.
REQ-030 The FIFO SHALL be a sub-module, gpu_instr_fifo, parameterized by DEPTH and the struct type.

Verification
REQ-031 Push OP_LINE x1=0,y1=0,x2=7,y2=3 at cycle N while idle -> line_start_o=1 at N+2; x2_o=7; busy_o=1 until line_done_i; then busy_o=0.
REQ-032 Push DEPTH+1 instructions while blocked in WAIT_LINE -> full_o=1 after DEPTH pushes; overflow_o pulses once; exactly DEPTH starts follow, in order.
REQ-033 Push opcode 4'b1111 -> bad_op_o pulses, no start pulse, FSM back in IDLE.
REQ-034 In WAIT_CIRCLE, pulse line_done_i -> no state change; then pulse circle_done_i -> IDLE.
REQ-035 Assert rst during WAIT_LINE with 2 entries queued -> empty_o=1, busy_o=0, no start pulse; a later line_done_i has no effect.
REQ-036 Push and pop in the same cycle at occupancy 2 -> occupancy stays 2 and the pointers wrap correctly across 3*DEPTH transfers.

Source files
------------

// File: rtl/gpu_instruction_scheduler_pkg.sv
// Shared types for the GPU instruction scheduler: operand widths, opcodes,
// FSM state encoding and the packed instruction record held in the FIFO.
package gpu_sched_pkg;

   localparam int WIDTH_BITS   = 10;
   localparam int HEIGHT_BITS  = 9;
   localparam int CHANNEL_BITS = 8;

   localparam logic [3:0] OP_LINE   = 4'b0100;
   localparam logic [3:0] OP_CIRCLE = 4'b0101;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DISPATCH    = 2'd1,
      WAIT_LINE   = 2'd2,
      WAIT_CIRCLE = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [3:0]              opcode;
      logic [WIDTH_BITS-1:0]   x1;
      logic [HEIGHT_BITS-1:0]  y1;
      logic [WIDTH_BITS-1:0]   x2;
      logic [HEIGHT_BITS-1:0]  y2;
      logic [WIDTH_BITS-1:0]   rad;
      logic [CHANNEL_BITS-1:0] r;
      logic [CHANNEL_BITS-1:0] g;
      logic [CHANNEL_BITS-1:0] b;
   } instr_t;

endpackage

// File: rtl/gpu_instruction_scheduler_if.sv
// Decoder-side instruction push port and raster-engine handshake of the
// scheduler; slave is the scheduler, master is whoever drives it.
interface gpu_sched_if;
   import gpu_sched_pkg::*;

   logic [3:0]              opcode_i;
   logic [WIDTH_BITS-1:0]   x1_i, x2_i, rad_i;
   logic [HEIGHT_BITS-1:0]  y1_i, y2_i;
   logic [CHANNEL_BITS-1:0] r_i, g_i, b_i;
   logic                    push_i;
   logic                    full_o, empty_o, overflow_o, bad_op_o;
   logic                    line_start_o, circle_start_o;
   logic                    line_done_i, circle_done_i;
   logic [WIDTH_BITS-1:0]   x1_o, x2_o, rad_o;
   logic [HEIGHT_BITS-1:0]  y1_o, y2_o;
   logic [CHANNEL_BITS-1:0] r_o, g_o, b_o;
   logic                    busy_o;

   modport slave (
      input  opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i, push_i,
      input  line_done_i, circle_done_i,
      output full_o, empty_o, overflow_o, bad_op_o, line_start_o, circle_start_o,
      output x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, busy_o
   );

   modport master (
      output opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i, push_i,
      output line_done_i, circle_done_i,
      input  full_o, empty_o, overflow_o, bad_op_o, line_start_o, circle_start_o,
      input  x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, busy_o
   );

endinterface

// File: rtl/gpu_instruction_scheduler_fifo.sv
// Instruction FIFO: power-of-two ring buffer with wrapping pointers and an
// occupancy counter one bit wider than the pointers.
module gpu_instr_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic pop_i,
   input  T     data_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   T            mem_q [DEPTH];
   T            mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   // Write acceptance looks only at current occupancy, so a same-cycle pop never frees a slot for a push.
   assign wr_en   = push_i && !full_o;
   assign rd_en   = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/gpu_instruction_scheduler.sv
// Queues decoded draw instructions and hands them one at a time to the line
// or circle raster engine, waiting for that engine's done pulse.
//
// state       | meaning
// IDLE        | waiting for a queued instruction; pops head into output register
// DISPATCH    | one start pulse (or bad_op) chosen by the opcode
// WAIT_LINE   | line engine busy, waiting for line_done_i
// WAIT_CIRCLE | circle engine busy, waiting for circle_done_i
module gpu_instruction_scheduler
   import gpu_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   gpu_sched_if.slave   bus
);

   sched_state_e state_q, state_d;
   instr_t       out_q, out_d;
   instr_t       push_instr, head_instr;
   logic         overflow_q, overflow_d;
   logic         pop, fifo_full, fifo_empty;
   logic         line_start, circle_start, bad_op;

   assign push_instr = '{opcode: bus.opcode_i, x1: bus.x1_i, y1: bus.y1_i,
                         x2: bus.x2_i, y2: bus.y2_i, rad: bus.rad_i,
                         r: bus.r_i, g: bus.g_i, b: bus.b_i};

   gpu_instr_fifo #(
      .DEPTH (DEPTH),
      .T     (instr_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.push_i),
      .pop_i   (pop),
      .data_i  (push_instr),
      .data_o  (head_instr),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         out_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      pop        = 1'b0;
      overflow_d = bus.push_i && fifo_full;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               out_d   = head_instr;
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            if (out_q.opcode == OP_LINE)        state_d = WAIT_LINE;
            else if (out_q.opcode == OP_CIRCLE) state_d = WAIT_CIRCLE;
            else                                state_d = IDLE;
         end
         WAIT_LINE:   if (bus.line_done_i)   state_d = IDLE;
         WAIT_CIRCLE: if (bus.circle_done_i) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      line_start   = 1'b0;
      circle_start = 1'b0;
      bad_op       = 1'b0;
      if (state_q == DISPATCH) begin
         if (out_q.opcode == OP_LINE)        line_start   = 1'b1;
         else if (out_q.opcode == OP_CIRCLE) circle_start = 1'b1;
         else                                bad_op       = 1'b1;
      end
   end

   assign bus.line_start_o   = line_start;
   assign bus.circle_start_o = circle_start;
   assign bus.bad_op_o       = bad_op;
   assign bus.overflow_o     = overflow_q;
   assign bus.full_o         = fifo_full;
   assign bus.empty_o        = fifo_empty;
   assign bus.busy_o         = (state_q != IDLE);
   assign bus.x1_o           = out_q.x1;
   assign bus.y1_o           = out_q.y1;
   assign bus.x2_o           = out_q.x2;
   assign bus.y2_o           = out_q.y2;
   assign bus.rad_o          = out_q.rad;
   assign bus.r_o            = out_q.r;
   assign bus.g_o            = out_q.g;
   assign bus.b_o            = out_q.b;

endmodule
